// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer wrapped around timer_60.
// Generates the timer_60 count enable from a prescaler and issues its clear.
// Extends the 00-59 seconds range with a minutes counter.
// Provides a display path that can be frozen while a lap time is shown.
module stopwatch_ctrl #(
  parameter int DIV     = 4,   // clk cycles per timer tick, >= 2
  parameter int MIN_MAX = 99   // last minutes value before wrapping, <= 127
) (
  input  logic       clk,
  input  logic       reset,        // asynchronous, active-low
  input  logic       start_stop,
  input  logic       lap_clear,
  input  logic [3:0] timer_low,
  input  logic [2:0] timer_high,
  output logic       timer_enable,
  output logic       timer_clear,
  output logic [3:0] disp_low,
  output logic [2:0] disp_high,
  output logic [6:0] disp_min,
  output logic       running,
  output logic       lap_active
);

  localparam int              PW         = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(DIV - 1);
  localparam logic [6:0]      MIN_LAST   = 7'(MIN_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  state_t          state_q,     state_d;
  logic [PW-1:0]   presc_q,     presc_d;
  logic [6:0]      minutes_q,   minutes_d;
  logic            tick_q,      tick_d;
  logic            clear_q,     clear_d;
  logic [3:0]      disp_low_q,  disp_low_d;
  logic [2:0]      disp_high_q, disp_high_d;
  logic [6:0]      disp_min_q,  disp_min_d;
  logic            running_q,   running_d;
  logic            lap_q,       lap_d;

  logic            counting;
  logic            presc_wrap;
  logic            minute_roll;

  assign counting    = (state_q == RUN) || (state_q == LAP);
  assign presc_wrap  = counting && (presc_q == PRESC_LAST);
  // Same edge on which timer_60 itself rolls 59 -> 00.
  assign minute_roll = tick_q && (timer_high == 3'd5) && (timer_low == 4'd9);

  // Next-state logic: transitions, prescaler, minutes and display capture.
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    minutes_d   = minutes_q;
    tick_d      = 1'b0;
    clear_d     = 1'b0;
    disp_low_d  = disp_low_q;
    disp_high_d = disp_high_q;
    disp_min_d  = disp_min_q;

    // Prescaler phase is kept in PAUSE so a resume continues mid-period.
    case (state_q)
      RUN, LAP: presc_d = presc_wrap ? '0 : presc_q + PW'(1);
      IDLE:     presc_d = '0;
      default:  presc_d = presc_q;
    endcase
    tick_d = presc_wrap;

    // start_stop has priority over lap_clear in every state.
    case (state_q)
      IDLE: begin
        if (start_stop)     state_d = RUN;
        else if (lap_clear) clear_d = 1'b1;
      end
      RUN: begin
        if (start_stop)     state_d = PAUSE;
        else if (lap_clear) state_d = LAP;
      end
      LAP: begin
        if (start_stop)     state_d = PAUSE;
        else if (lap_clear) state_d = RUN;
      end
      PAUSE: begin
        if (start_stop) begin
          state_d = RUN;
        end else if (lap_clear) begin
          state_d = IDLE;
          clear_d = 1'b1;
          presc_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Clearing the timer also clears the minutes it extends.
    if (clear_d)          minutes_d = '0;
    else if (minute_roll) minutes_d = (minutes_q == MIN_LAST) ? 7'd0 : minutes_q + 7'd1;

    // Display follows live values except while a lap time is held.
    if (state_q != LAP) begin
      disp_low_d  = timer_low;
      disp_high_d = timer_high;
      disp_min_d  = minutes_q;
    end

    running_d = (state_d == RUN) || (state_d == LAP);
    lap_d     = (state_d == LAP);
  end

  // All state and registered outputs, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      minutes_q   <= '0;
      tick_q      <= 1'b0;
      clear_q     <= 1'b0;
      disp_low_q  <= '0;
      disp_high_q <= '0;
      disp_min_q  <= '0;
      running_q   <= 1'b0;
      lap_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      minutes_q   <= minutes_d;
      tick_q      <= tick_d;
      clear_q     <= clear_d;
      disp_low_q  <= disp_low_d;
      disp_high_q <= disp_high_d;
      disp_min_q  <= disp_min_d;
      running_q   <= running_d;
      lap_q       <= lap_d;
    end
  end

  assign timer_enable = tick_q;
  assign timer_clear  = clear_q;
  assign disp_low     = disp_low_q;
  assign disp_high    = disp_high_q;
  assign disp_min     = disp_min_q;
  assign running      = running_q;
  assign lap_active   = lap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: a behavioural timer_60 plus an elapsed-tick
// reference model, checked every cycle under directed and random buttons.
module tb_stopwatch_ctrl;

  localparam int DIV     = 4;
  localparam int MIN_MAX = 99;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_LAP   = 2;
  localparam int S_PAUSE = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_stop;
  logic       lap_clear;
  logic [3:0] timer_low;
  logic [2:0] timer_high;
  logic       timer_enable;
  logic       timer_clear;
  logic [3:0] disp_low;
  logic [2:0] disp_high;
  logic [6:0] disp_min;
  logic       running;
  logic       lap_active;

  stopwatch_ctrl #(.DIV(DIV), .MIN_MAX(MIN_MAX)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_stop   (start_stop),
    .lap_clear    (lap_clear),
    .timer_low    (timer_low),
    .timer_high   (timer_high),
    .timer_enable (timer_enable),
    .timer_clear  (timer_clear),
    .disp_low     (disp_low),
    .disp_high    (disp_high),
    .disp_min     (disp_min),
    .running      (running),
    .lap_active   (lap_active)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: mode, cycles into the current tick period, expected
  // pulses, ticks elapsed since the last clear, and the timer_60 seconds.
  int m_state, m_phase, m_en, m_clr, m_elapsed, m_tsec;
  int m_dl, m_dh, m_dm, m_run, m_lap;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_phase = 0; m_en = 0; m_clr = 0;
    m_elapsed = 0; m_tsec = 0;
    m_dl = 0; m_dh = 0; m_dm = 0; m_run = 0; m_lap = 0;
  endtask

  // One clock edge of the specified behaviour, using pre-edge values.
  task automatic model_edge(input bit ss, input bit lc);
    int  nstate;
    int  nphase;
    int  nen;
    int  nclr;
    bit  counting;
    nstate   = m_state;
    nclr     = 0;
    counting = (m_state == S_RUN) || (m_state == S_LAP);

    if (m_state != S_LAP) begin
      m_dm = (m_elapsed / 60) % (MIN_MAX + 1);
      m_dl = m_tsec % 10;
      m_dh = m_tsec / 10;
    end

    nen = (counting && ((m_phase + 1) % DIV == 0)) ? 1 : 0;
    if (counting)                nphase = (m_phase + 1) % DIV;
    else if (m_state == S_IDLE)  nphase = 0;
    else                         nphase = m_phase;

    if (ss) begin
      if (m_state == S_IDLE || m_state == S_PAUSE) nstate = S_RUN;
      else                                         nstate = S_PAUSE;
    end else if (lc) begin
      case (m_state)
        S_IDLE:  nclr = 1;
        S_RUN:   nstate = S_LAP;
        S_LAP:   nstate = S_RUN;
        default: begin nstate = S_IDLE; nclr = 1; nphase = 0; end
      endcase
    end

    // timer_60 acts on the pulses visible before this edge.
    if (m_clr != 0)     m_tsec = 0;
    else if (m_en != 0) m_tsec = (m_tsec + 1) % 60;

    if (nclr != 0)      m_elapsed = 0;
    else if (m_en != 0) m_elapsed = m_elapsed + 1;

    m_state = nstate;
    m_phase = nphase;
    m_en    = nen;
    m_clr   = nclr;
    m_run   = (nstate == S_RUN || nstate == S_LAP) ? 1 : 0;
    m_lap   = (nstate == S_LAP) ? 1 : 0;
  endtask

  task automatic check_outputs();
    chk("timer_enable", 32'(timer_enable), 32'(m_en));
    chk("timer_clear",  32'(timer_clear),  32'(m_clr));
    chk("disp_low",     32'(disp_low),     32'(m_dl));
    chk("disp_high",    32'(disp_high),    32'(m_dh));
    chk("disp_min",     32'(disp_min),     32'(m_dm));
    chk("running",      32'(running),      32'(m_run));
    chk("lap_active",   32'(lap_active),   32'(m_lap));
  endtask

  // Called at a negedge: drive buttons for one cycle, advance, then check.
  task automatic step(input bit ss, input bit lc);
    start_stop = ss;
    lap_clear  = lc;
    if (ss || lc)
      $display("t=%0t start_stop=%0b lap_clear=%0b state_before=%0d", $time, ss, lc, m_state);
    @(posedge clk);
    model_edge(ss, lc);
    @(negedge clk);
    start_stop = 1'b0;
    lap_clear  = 1'b0;
    timer_low  = 4'(m_tsec % 10);
    timer_high = 3'(m_tsec / 10);
    check_outputs();
  endtask

  task automatic random_steps(input int n);
    int r;
    for (int i = 0; i < n; i++) begin
      r = int'($urandom_range(0, 99));
      step(r < 3 || r == 6, (r >= 3 && r < 7));
    end
  endtask

  initial begin
    reset      = 1'b1;
    start_stop = 1'b0;
    lap_clear  = 1'b0;
    timer_low  = 4'd0;
    timer_high = 3'd0;
    model_reset();
    #1 reset = 1'b0;
    #1 check_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_outputs();

    // Start, then run long enough for 6000+ ticks so minutes wraps past 99.
    repeat (3) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (24100) step(1'b0, 1'b0);

    // Lap hold and release, pause/resume phase, simultaneous press, clear.
    step(1'b0, 1'b1);
    repeat (32) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    step(1'b1, 1'b0);

    random_steps(4000);

    // Make sure we are running, then reset between edges.
    if (m_state == S_IDLE || m_state == S_PAUSE) step(1'b1, 1'b0);
    repeat (7) step(1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    timer_low  = 4'd0;
    timer_high = 3'd0;
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (20) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    random_steps(1500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control FSM that sequences timer_60 as a stopwatch. It drives timer_60's count enable from a clock prescaler and issues its clear. It extends timer_60's 00–59 range with a minutes counter and provides a lap-hold display. It sits between two debounced single-cycle button pulses and the display decoders, with timer_60 as its controlled datapath.

Parameters:
DIV, 4, clk cycles per timer tick; must be ≥2. Prescaler width is clog2(DIV).
MIN_MAX, 99, last minutes value before the minutes counter wraps to 0; must be ≤127.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-low reset; all state is cleared while reset=0
start_stop  input  1  single-cycle pulse, synchronous to clk
lap_clear  input  1  single-cycle pulse, synchronous to clk
timer_low  input  4  timer_60 low_digit, 0–9
timer_high  input  3  timer_60 high_digit, 0–5
timer_enable  output  1  registered one-cycle tick to timer_60 enable
timer_clear  output  1  registered one-cycle, active-high clear to timer_60
disp_low  output  4  displayed seconds units
disp_high  output  3  displayed seconds tens
disp_min  output  7  displayed minutes
running  output  1  high in RUN or LAP
lap_active  output  1  high in LAP

Behaviour:
- Clocking: one clock; reset is asynchronous and active-low.
- Reset values (reset=0):
  - state=IDLE; prescaler=0; minutes=0.
  - timer_enable=0; timer_clear=0.
  - disp_low=0; disp_high=0; disp_min=0.
  - running=0; lap_active=0.
- State encodings: IDLE=0, RUN=1, LAP=2, PAUSE=3.
- Transitions (evaluated on the sampling edge):
  - IDLE:
    - start_stop → RUN.
    - lap_clear → stay IDLE and pulse timer_clear.
  - RUN:
    - start_stop → PAUSE.
    - lap_clear → LAP; the display registers freeze at their current values.
  - LAP:
    - start_stop → PAUSE; the display returns to live.
    - lap_clear → RUN; the display returns to live.
  - PAUSE:
    - start_stop → RUN.
    - lap_clear → IDLE; pulse timer_clear; minutes=0; prescaler=0.
- Simultaneous start_stop and lap_clear: start_stop wins and lap_clear is ignored.
- Prescaler:
  - Counts only in RUN and LAP, wrapping after DIV-1.
  - Holds its value in PAUSE, so phase is preserved across a pause.
  - Forced to 0 in IDLE.
- timer_enable:
  - High for exactly the cycle after an edge where the prescaler wrapped in RUN or LAP.
  - First pulse arrives DIV cycles after start_stop is sampled from IDLE; subsequent pulses every DIV cycles.
  - Never high in IDLE or PAUSE.
  - A tick already registered when start_stop moves RUN→PAUSE is still delivered; no further ticks follow.
- Minutes:
  - Increment on any edge where timer_enable=1, timer_high=5 and timer_low=9, i.e. the same edge on which timer_60 wraps 59→00.
  - Wrap from MIN_MAX to 0.
  - Cleared together with any timer_clear pulse.
- timer_clear: exactly one cycle high, in the cycle after the lap_clear that triggers it. Otherwise 0.
- Display:
  - Outside LAP, disp_* are registered copies of {timer_high, timer_low, minutes}, with one cycle of latency.
  - In LAP they hold their last values.
  - When LAP is left, they track live values again from the next edge.
- Inputs are assumed legal (BCD ranges). Out-of-range timer digits only affect minutes detection, which requires exact 5/9.
- Reset mid-operation: asynchronous return to the reset values. Any pending tick or clear is dropped.

Test Plan:
- DIV=4. Reset low for 2 cycles, release, start_stop at cycle 5 → timer_enable high at cycles 9, 13, 17, …, one cycle wide; running=1.
- Run 60 ticks → timer wraps 59→00 on tick 60; disp_min=1 with disp_high=0, disp_low=0 one cycle later. Preload minutes to 99 via 6000 ticks (or a forced check) → wraps to 0.
- At display 0:12, pulse lap_clear → lap_active=1 and disp holds 0:12 while ticks continue to 0:20. Pulse lap_clear → disp shows 0:20 one cycle later; lap_active=0.
- Pause 2 cycles after a tick → no timer_enable during 10 PAUSE cycles. start_stop → next tick exactly 2 cycles after resume (phase preserved).
- In PAUSE, lap_clear → timer_clear high exactly one cycle; disp_min=0; state IDLE. In RUN, start_stop and lap_clear in the same cycle → PAUSE, lap_active stays 0.
- Assert reset mid-RUN between clock edges → all outputs zero immediately, without waiting for an edge. After release, no tick until the next start_stop.
